muldiv_hilo_ctrl: RTL and testbench
===================================

// Module: muldiv_hilo_ctrl
// PURPOSE
//  Multi-cycle sequencer for MIPS mult/multu/div/divu that owns the HI/LO register pair.
//  Replaces the single-cycle product path and the clocked HI/LO side-path of the datapath ALU.
//  Sits beside the EX stage and accepts one op per op_valid/op_ready handshake.
//  Asserts stall while the decode stage waits on a busy unit.
// PARAMETERS
//  WIDTH  32  operand width; iteration count = WIDTH; HI/LO are WIDTH bits each
// PORTS
//  clk        in   1      clock, all state updates on posedge
//  rst        in   1      synchronous, active-high reset
//  flush      in   1      abort in-flight op (pipeline flush / exception)
//  op_valid   in   1      op/a/b valid this cycle
//  op         in   3      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MFHI, 111 MFLO
//  a          in   WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO source)
//  b          in   WIDTH  rt operand (multiplier / divisor)
//  op_ready   out  1      (state==IDLE) && !flush; op accepted on posedge when op_valid && op_ready
//  stall      out  1      op_valid && !op_ready (combinational)
//  busy       out  1      state != IDLE
//  done       out  1      one-cycle pulse: MULT/DIV result written to HI/LO
//  rd_valid   out  1      one-cycle pulse: rd_data carries MFHI/MFLO result
//  rd_data    out  WIDTH  registered HI or LO read data
//  hi, lo     out  WIDTH  current HI/LO register contents
// BEHAVIOUR
//  Reset: state=IDLE; hi=lo=rd_data=0; done=rd_valid=busy=0; counter=0. Reset overrides flush and op_valid.
//  States: IDLE, MUL, DIV, FIX.
//   IDLE -> MUL on accepted MULT/MULTU; IDLE -> DIV on accepted DIV/DIVU.
//   MUL/DIV -> FIX when the counter reaches 0 (WIDTH iterations, counter WIDTH-1..0).
//   FIX -> IDLE always: applies sign correction, writes hi/lo, sets done=1 for the following cycle.
//   Any state -> IDLE on flush: hi/lo unchanged, no done, datapath regs don't care.
//  Latency: op accepted on edge k; busy=1 in cycles k+1..k+WIDTH+1.
//   hi/lo and done=1 become visible after edge k+WIDTH+1; op_ready is 1 in that same cycle.
//  Operands are captured at accept; a/b may change afterwards.
//  MULT (signed): operate on magnitudes with shift-add, one partial product per cycle.
//   Negate the 2*WIDTH product in FIX when sign(a)^sign(b). {hi,lo} = full 2*WIDTH product.
//  DIV (signed): restoring division on magnitudes, one quotient bit per cycle.
//   Quotient truncates toward zero (negated if sign(a)^sign(b)); remainder takes the sign of a.
//   Result: lo=quotient, hi=remainder.
//  Divide by zero (DIV/DIVU): lo={WIDTH{1}}, hi=a. Takes full latency, no flag.
//  DIV of 0x8000_0000 by -1: lo=0x8000_0000, hi=0 (wraps).
//  MTHI/MTLO: single cycle; hi (lo) <= a on the accept edge. State stays IDLE, no done, no rd_valid.
//  MFHI/MFLO: single cycle; rd_data <= hi (lo) on the accept edge.
//   rd_valid=1 for the next cycle only. rd_data holds its value otherwise.
//  MF* or MT* while busy is not accepted; stall=1 until op_ready. The first cycle op_ready=1 is the done cycle.
//   MFHI/MFLO accepted then reads the new hi/lo.
//  flush && op_valid in IDLE: op not accepted (op_ready=0). Flush in IDLE has no other effect.
//  done and rd_valid never both 1 in the same cycle.
// TESTING
//  1 MULT a=0xFFFF_FFFD(-3) b=7 -> done exactly WIDTH+1=33 cycles after accept; hi=0xFFFF_FFFF lo=0xFFFF_FFEB
//  2 MULTU a=b=0xFFFF_FFFF -> hi=0xFFFF_FFFE lo=0x0000_0001
//  3 DIV a=-7 b=2 -> lo=0xFFFF_FFFD hi=0xFFFF_FFFF. DIVU a=7 b=0 -> lo=0xFFFF_FFFF hi=7. DIV 0x8000_0000/-1 -> lo=0x8000_0000 hi=0
//  4 MFLO presented 5 cycles into MULT 6*7 -> stall=1 until done cycle; accepted there; next cycle rd_valid=1 rd_data=42
//  5 flush in 10th busy cycle of DIV (prior hi=0x11 lo=0x22) -> busy=0 next cycle; no done; hi/lo stay 0x11/0x22
//  6 rst during MUL -> all outputs 0 next cycle; then MTHI a=0x1234, MFHI -> rd_valid=1 rd_data=0x1234 one cycle after MFHI accept

Source files
------------

// File: rtl/muldiv_hilo_ctrl.sv
// Multi-cycle MIPS mult/multu/div/divu sequencer that owns the HI/LO pair and serves MT*/MF* accesses.
`timescale 1ns/1ps
module muldiv_hilo_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             op_ready,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_MFHI  = 3'b110;
    localparam logic [2:0] OP_MFLO  = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_p;
    logic [WIDTH-1:0]   r_m;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_rd_data;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_div0;
    logic               r_done;
    logic               r_rd_valid;

    logic               w_accept;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_shift;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_sub;
    logic [2*WIDTH-1:0] w_p_step;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_q_fix;
    logic [WIDTH-1:0]   w_r_fix;

    assign op_ready = (r_state == S_IDLE) && !flush;
    assign stall    = op_valid && !op_ready;
    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;
    assign hi       = r_hi;
    assign lo       = r_lo;

    assign w_accept = op_valid && op_ready;

    // op[0]=1 selects the unsigned variants; signed ops work on magnitudes.
    assign w_a_neg = !op[0] && a[WIDTH-1];
    assign w_b_neg = !op[0] && b[WIDTH-1];
    assign w_a_mag = w_a_neg ? (~a + 1'b1) : a;
    assign w_b_mag = w_b_neg ? (~b + 1'b1) : b;

    // r_p holds {accumulator, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
    always_comb begin
        w_mul_sum   = {1'b0, r_p[2*WIDTH-1:WIDTH]} + {1'b0, (r_p[0] ? r_m : {WIDTH{1'b0}})};
        w_div_shift = {r_p[2*WIDTH-1:WIDTH], r_p[WIDTH-1]};
        w_div_ge    = (w_div_shift >= {1'b0, r_m});
        w_div_sub   = w_div_shift[WIDTH-1:0] - r_m;
        w_p_step    = {w_mul_sum, r_p[WIDTH-1:1]};
        if (r_is_div) begin
            if (w_div_ge) begin
                w_p_step = {w_div_sub, r_p[WIDTH-2:0], 1'b1};
            end else begin
                w_p_step = {w_div_shift[WIDTH-1:0], r_p[WIDTH-2:0], 1'b0};
            end
        end
    end

    // With a zero divisor the remainder path naturally yields |a|, so hi still ends up equal to a.
    always_comb begin
        w_prod_fix = r_neg_q ? (~r_p + 1'b1) : r_p;
        w_q_fix    = r_neg_q ? (~r_p[WIDTH-1:0] + 1'b1) : r_p[WIDTH-1:0];
        w_r_fix    = r_neg_r ? (~r_p[2*WIDTH-1:WIDTH] + 1'b1) : r_p[2*WIDTH-1:WIDTH];
        if (r_div0) begin
            w_q_fix = {WIDTH{1'b1}};
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept && !op[2]) begin
                        w_state_next = op[1] ? S_DIV : S_MUL;
                    end
                end
                S_MUL, S_DIV: begin
                    if (r_cnt == '0) begin
                        w_state_next = S_FIX;
                    end
                end
                S_FIX:   w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_p        <= '0;
            r_m        <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_rd_data  <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div0     <= 1'b0;
            r_done     <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_rd_valid <= 1'b0;
            if (w_accept) begin
                case (op)
                    OP_MULT, OP_MULTU: begin
                        r_p      <= {{WIDTH{1'b0}}, w_b_mag};
                        r_m      <= w_a_mag;
                        r_is_div <= 1'b0;
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= 1'b0;
                        r_div0   <= 1'b0;
                        r_cnt    <= CW'(WIDTH - 1);
                    end
                    OP_DIV, OP_DIVU: begin
                        r_p      <= {{WIDTH{1'b0}}, w_a_mag};
                        r_m      <= w_b_mag;
                        r_is_div <= 1'b1;
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_div0   <= (b == '0);
                        r_cnt    <= CW'(WIDTH - 1);
                    end
                    OP_MTHI: r_hi <= a;
                    OP_MTLO: r_lo <= a;
                    OP_MFHI: begin
                        r_rd_data  <= r_hi;
                        r_rd_valid <= 1'b1;
                    end
                    OP_MFLO: begin
                        r_rd_data  <= r_lo;
                        r_rd_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end else if (!flush) begin
                if (r_state == S_MUL || r_state == S_DIV) begin
                    r_p   <= w_p_step;
                    r_cnt <= r_cnt - 1'b1;
                end else if (r_state == S_FIX) begin
                    if (r_is_div) begin
                        r_hi <= w_r_fix;
                        r_lo <= w_q_fix;
                    end else begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end
                    r_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Scoreboard bench for muldiv_hilo_ctrl: directed ops push expected HI/LO or read data, a monitor checks results.
`timescale 1ns/1ps
module tb_muldiv_hilo_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         op_valid;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         op_ready;
    logic         stall;
    logic         busy;
    logic         done;
    logic         rd_valid;
    logic [W-1:0] rd_data;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    typedef struct packed {
        logic         is_rd;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_lat;
    bit   done_at_acc;

    muldiv_hilo_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .op_valid (op_valid),
        .op       (op),
        .a        (a),
        .b        (b),
        .op_ready (op_ready),
        .stall    (stall),
        .busy     (busy),
        .done     (done),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every done / rd_valid pulse consumes exactly one scoreboard entry.
    always @(negedge clk) begin
        if (!rst) begin
            if (done && rd_valid) begin
                n_vec++;
                n_err++;
                $display("FAIL done_rd_exclusive: done=%b rd_valid=%b both high", done, rd_valid);
            end
            if (done || rd_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_result: done=%b rd_valid=%b hi=%h lo=%h rd_data=%h", done, rd_valid, hi, lo, rd_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("result_kind", {63'b0, rd_valid}, {63'b0, mon_e.is_rd});
                    if (mon_e.is_rd) begin
                        chk("rd_data", {32'b0, rd_data}, {32'b0, mon_e.lo});
                        $display("txn read: rd_data=%h expected %h", rd_data, mon_e.lo);
                    end else begin
                        chk("hilo", {hi, lo}, {mon_e.hi, mon_e.lo});
                        $display("txn arith: hi=%h lo=%h expected %h/%h", hi, lo, mon_e.hi, mon_e.lo);
                    end
                end
            end
        end
    end

    task automatic issue(input logic [2:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                         input bit push, input bit is_rd, input logic [W-1:0] ehi,
                         input logic [W-1:0] elo, output bit done_seen);
        bit   ok;
        exp_t e;
        ok        = 1'b0;
        done_seen = 1'b0;
        op_valid  = 1'b1;
        op        = o;
        a         = aa;
        b         = bb;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (op_ready) begin
                ok        = 1'b1;
                done_seen = done;
                break;
            end
            chk("stall_while_blocked", {63'b0, stall}, 64'd1);
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: op=%0d not accepted within 100 cycles", o);
        end else begin
            chk("stall_when_ready", {63'b0, stall}, 64'd0);
            if (push) begin
                e.is_rd = is_rd;
                e.hi    = ehi;
                e.lo    = elo;
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        a        = ~aa;
        b        = ~bb;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            n = i;
            if (done) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        flush    = 1'b0;
        op_valid = 1'b0;
        op       = 3'd0;
        a        = '0;
        b        = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_busy",     {63'b0, busy},     64'd0);
        chk("reset_done",     {63'b0, done},     64'd0);
        chk("reset_rd_valid", {63'b0, rd_valid}, 64'd0);
        chk("reset_hilo",     {hi, lo},          64'd0);
        chk("reset_rd_data",  {32'b0, rd_data},  64'd0);
        chk("reset_op_ready", {63'b0, op_ready}, 64'd1);

        // Signed MULT latency and result
        issue(3'd0, 32'hFFFF_FFFD, 32'd7, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, done_at_acc);
        chk("mult_busy", {63'b0, busy}, 64'd1);
        wait_done(n_lat);
        chk("mult_latency", 64'(n_lat), 64'd33);
        chk("done_op_ready", {63'b0, op_ready}, 64'd1);

        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001, done_at_acc);
        wait_done(n_lat);
        chk("multu_done", {63'b0, done}, 64'd1);

        issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, done_at_acc);
        wait_done(n_lat);
        chk("div_done", {63'b0, done}, 64'd1);

        issue(3'd3, 32'd7, 32'd0, 1'b1, 1'b0, 32'h0000_0007, 32'hFFFF_FFFF, done_at_acc);
        wait_done(n_lat);
        chk("divu_zero_latency", 64'(n_lat), 64'd33);

        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0000_0000, 32'h8000_0000, done_at_acc);
        wait_done(n_lat);
        chk("div_ovf_done", {63'b0, done}, 64'd1);

        // 7 / -2: quotient -3, remainder keeps the sign of the dividend (+1)
        issue(3'd2, 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0, 32'h0000_0001, 32'hFFFF_FFFD, done_at_acc);
        wait_done(n_lat);
        chk("div_neg_divisor_done", {63'b0, done}, 64'd1);

        // MFLO presented 5 cycles into MULT 6*7 stalls until the done cycle
        issue(3'd0, 32'd6, 32'd7, 1'b1, 1'b0, 32'd0, 32'd42, done_at_acc);
        repeat (4) @(posedge clk);
        #1;
        issue(3'd7, 32'd0, 32'd0, 1'b1, 1'b1, 32'd0, 32'd42, done_at_acc);
        chk("mflo_accept_in_done_cycle", {63'b0, done_at_acc}, 64'd1);
        chk("mflo_rd_valid", {63'b0, rd_valid}, 64'd1);
        @(posedge clk);
        #1;
        chk("mflo_rd_valid_pulse", {63'b0, rd_valid}, 64'd0);

        // Flush in the 10th busy cycle of a DIV
        issue(3'd4, 32'h11, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, done_at_acc);
        chk("mthi_hi", {32'b0, hi}, 64'h11);
        issue(3'd5, 32'h22, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, done_at_acc);
        chk("mtlo_lo", {32'b0, lo}, 64'h22);
        issue(3'd2, 32'd100, 32'd3, 1'b0, 1'b0, 32'd0, 32'd0, done_at_acc);
        repeat (9) @(posedge clk);
        #1;
        chk("div_busy_before_flush", {63'b0, busy}, 64'd1);
        flush = 1'b1;
        #1;
        chk("flush_op_ready", {63'b0, op_ready}, 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_busy", {63'b0, busy}, 64'd0);
        chk("flush_hilo", {hi, lo}, {32'h11, 32'h22});
        repeat (40) @(posedge clk);
        #1;
        chk("flush_hilo_later", {hi, lo}, {32'h11, 32'h22});

        // Flush while idle blocks an MTHI
        op_valid = 1'b1;
        op       = 3'd4;
        a        = 32'h99;
        flush    = 1'b1;
        #1;
        chk("idle_flush_op_ready", {63'b0, op_ready}, 64'd0);
        chk("idle_flush_stall",    {63'b0, stall},    64'd1);
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        flush    = 1'b0;
        chk("idle_flush_hi", {32'b0, hi}, 64'h11);

        // Reset during MUL clears everything
        issue(3'd0, 32'd5, 32'd5, 1'b0, 1'b0, 32'd0, 32'd0, done_at_acc);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_busy",     {63'b0, busy},     64'd0);
        chk("rst_done",     {63'b0, done},     64'd0);
        chk("rst_rd_valid", {63'b0, rd_valid}, 64'd0);
        chk("rst_hilo",     {hi, lo},          64'd0);
        chk("rst_rd_data",  {32'b0, rd_data},  64'd0);
        rst = 1'b0;
        issue(3'd4, 32'h1234, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, done_at_acc);
        issue(3'd6, 32'd0, 32'd0, 1'b1, 1'b1, 32'd0, 32'h1234, done_at_acc);
        chk("mfhi_rd_valid", {63'b0, rd_valid}, 64'd1);
        chk("mfhi_rd_data", {32'b0, rd_data}, 64'h1234);

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
